// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types and helpers for the tug-of-war referee
// Holds the round state enum, LFSR tap masks and the rope centre helper.
package tow_pkg;

  typedef enum logic [1:0] {
    WAIT,
    ARMED,
    DONE
  } state_t;

  // Maximal-length Fibonacci tap masks; bit k set means stage k+1 feeds back.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h00B8;
    endcase
  endfunction

  function automatic int centre_pos(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tow_btn_pulse.sv
// rtl/tow_btn_pulse.sv - raw pushbutton to single-clock press pulse
// Two-flop synchronizer, then a registered rising-edge detect.
module tow_btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic [2:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 3'b000;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], raw};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/tow_referee.sv
// rtl/tow_referee.sv - tug-of-war referee: rounds, fouls, ties and rope position
// Optional TOW_DONE_FLASH_EN flashes the rope bar on each slowenable once the match is won.
module tow_referee
  import tow_pkg::*;
#(
  parameter int          N_LEDS      = 7,
  parameter int          LFSR_W      = 8,
  parameter int          DELAY_MIN   = 2,
  parameter int          ARM_TIMEOUT = 64,
  parameter int unsigned SEED        = 32'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slowenable,
  input  logic              pbl,
  input  logic              pbr,
  output logic [N_LEDS-1:0] led,
  output logic              leds_on,
  output logic              done,
  output logic              winner_right,
  output logic [1:0]        foul,
  output logic              round_pulse
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0]     CENTRE   = PW'(centre_pos(N_LEDS));
  localparam logic [PW-1:0]     LAST     = PW'(N_LEDS - 1);
  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_W'(SEED) == '0) ? LFSR_W'(1) : LFSR_W'(SEED);
  localparam logic [15:0]       DLY_RST  = 16'(DELAY_MIN) + {12'd0, SEED_EFF[3:0]};

  logic              pl;
  logic              pr;
  state_t            state;
  logic [PW-1:0]     pos;
  logic [LFSR_W-1:0] lfsr;
  logic [15:0]       dly;
  logic [15:0]       tmo;
  logic [15:0]       dly_load;
  logic              step_right;
  logic              step_left;
  logic [PW-1:0]     next_pos;
  logic              hit_end;
  logic [N_LEDS-1:0] onehot;

  tow_btn_pulse u_btn_l (.clk(clk), .rst(rst), .raw(pbl), .pulse(pl));
  tow_btn_pulse u_btn_r (.clk(clk), .rst(rst), .raw(pbr), .pulse(pr));

  // A lone press in WAIT is a foul that moves the rope toward the other player.
  always_comb begin
    step_right = 1'b0;
    step_left  = 1'b0;
    case (state)
      WAIT: begin
        step_right = pl & ~pr;
        step_left  = pr & ~pl;
      end
      ARMED: begin
        step_right = pr & ~pl;
        step_left  = pl & ~pr;
      end
      default: ;
    endcase
    next_pos = pos;
    if (step_right)     next_pos = pos - PW'(1);
    else if (step_left) next_pos = pos + PW'(1);
    hit_end  = (step_right | step_left) && (next_pos == '0 || next_pos == LAST);
    dly_load = 16'(DELAY_MIN) + {12'd0, lfsr[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT;
      pos          <= CENTRE;
      lfsr         <= SEED_EFF;
      dly          <= DLY_RST;
      tmo          <= '0;
      done         <= 1'b0;
      winner_right <= 1'b0;
      foul         <= 2'b00;
      round_pulse  <= 1'b0;
    end else begin
      foul        <= 2'b00;
      round_pulse <= 1'b0;
      if (slowenable) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
      case (state)
        WAIT, ARMED: begin
          if (pl | pr) begin
            round_pulse <= 1'b1;
            pos         <= next_pos;
            if (state == WAIT) foul <= {pl, pr};
            if (hit_end) begin
              state        <= DONE;
              done         <= 1'b1;
              winner_right <= (next_pos == '0);
            end else begin
              state <= WAIT;
              dly   <= dly_load;
            end
          end else if (slowenable) begin
            if (state == WAIT) begin
              if (dly <= 16'd1) begin
                state <= ARMED;
                tmo   <= 16'(ARM_TIMEOUT);
              end else begin
                dly <= dly - 16'd1;
              end
            end else begin
              // Nobody pressed in time: void the round silently.
              if (tmo <= 16'd1) begin
                state <= WAIT;
                dly   <= dly_load;
              end else begin
                tmo <= tmo - 16'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign onehot  = {{(N_LEDS-1){1'b0}}, 1'b1} << pos;
  assign leds_on = (state != WAIT);

`ifdef TOW_DONE_FLASH_EN
  logic flash;

  always_ff @(posedge clk) begin
    if (rst || state != DONE) flash <= 1'b0;
    else if (slowenable)      flash <= ~flash;
  end

  assign led = (state == WAIT) ? '0 : (flash ? '1 : onehot);
`else
  assign led = (state == WAIT) ? '0 : onehot;
`endif

endmodule
